// File: rtl/bus_master_arb.sv
// bus_master_arb: round-robin arbiter that hands the 68000 bus to FPGA-internal masters via BR/BG/BGACK
//   cpuclk, rst_n   : clock (rising edge), asynchronous active-low reset
//   arb_en          : arbiter enable
//   req / gnt       : per-requester level request / registered one-hot grant
//   bus_own         : OR of gnt
//   owner_id        : index of the last/current winner
//   br_n, bgack_n   : 68000 bus request / grant acknowledge (outputs)
//   bg_n, as_n      : 68000 bus grant / address strobe (asynchronous inputs)
//   err_clr, bg_err : clear pulse / sticky grant-timeout flag
//   tenure_exp      : one-cycle pulse when an owner is forcibly released
// Optional watchdog enabled by macro BUS_ARB_WATCHDOG_EN; without it bg_err and tenure_exp are tied low.
module bus_master_arb #(
    parameter int NREQ       = 3,
    parameter int OWNER_W    = 3,
    parameter int BG_TIMEOUT = 255,
    parameter int MAX_TENURE = 1024
) (
    input  logic               cpuclk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    gnt,
    output logic               bus_own,
    output logic [OWNER_W-1:0] owner_id,
    output logic               br_n,
    input  logic               bg_n,
    input  logic               as_n,
    output logic               bgack_n,
    input  logic               err_clr,
    output logic               bg_err,
    output logic               tenure_exp
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_AS, OWN, RELEASE} state_t;
    state_t             state;
    logic [1:0]         bg_sync, as_sync;
    logic               bg_s, as_s;
    logic [OWNER_W-1:0] rr, win_id;
    logic [NREQ-1:0]    win_oh, own_oh;
    logic               bg_to, ten_to, own_req;
    assign bg_s    = bg_sync[1];
    assign as_s    = as_sync[1];
    assign own_req = |(req & own_oh);
    // First set request searching upward from rr+1; smallest offset is assigned last and wins.
    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = NREQ; i >= 1; i--)
            for (int j = 0; j < NREQ; j++)
                if (req[j] && j == (int'(rr) + i) % NREQ) begin
                    win_id = OWNER_W'(j);
                    win_oh = NREQ'(1) << j;
                end
    end
`ifdef BUS_ARB_WATCHDOG_EN
    localparam int CW = $clog2((BG_TIMEOUT > MAX_TENURE ? BG_TIMEOUT : MAX_TENURE) + 1);
    logic [CW-1:0] cnt;
    assign bg_to  = state == REQ && cnt == CW'(BG_TIMEOUT - 1);
    assign ten_to = state == OWN && cnt == CW'(MAX_TENURE - 1);
    // IDLE and WAIT_AS always last at least one cycle, so the counter is zero on entry to REQ/OWN.
    always_ff @(posedge cpuclk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            bg_err     <= 1'b0;
            tenure_exp <= 1'b0;
        end else begin
            cnt        <= (state == REQ || state == OWN) ? cnt + 1'b1 : '0;
            bg_err     <= (bg_to && bg_s && arb_en) || (bg_err && !err_clr);
            tenure_exp <= ten_to && own_req;
        end
`else
    logic unused_wd;
    assign unused_wd  = err_clr ^ (BG_TIMEOUT > 0) ^ (MAX_TENURE > 0);
    assign bg_to      = 1'b0;
    assign ten_to     = 1'b0;
    assign bg_err     = 1'b0;
    assign tenure_exp = 1'b0;
`endif
    always_ff @(posedge cpuclk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            bg_sync  <= '1;
            as_sync  <= '1;
            rr       <= OWNER_W'(NREQ - 1);
            own_oh   <= '0;
            gnt      <= '0;
            bus_own  <= 1'b0;
            owner_id <= '0;
            br_n     <= 1'b1;
            bgack_n  <= 1'b1;
        end else begin
            bg_sync <= {bg_sync[0], bg_n};
            as_sync <= {as_sync[0], as_n};
            case (state)
                IDLE:
                    if (arb_en && |req) begin
                        state    <= REQ;
                        owner_id <= win_id;
                        own_oh   <= win_oh;
                        br_n     <= 1'b0;
                    end
                REQ:
                    if (!bg_s)
                        state <= WAIT_AS;
                    else if (!arb_en || bg_to) begin
                        state <= IDLE;
                        br_n  <= 1'b1;
                        rr    <= bg_to ? owner_id : rr;
                    end
                WAIT_AS:
                    if (as_s) begin
                        state   <= OWN;
                        bgack_n <= 1'b0;
                        br_n    <= 1'b1;
                        gnt     <= own_oh;
                        bus_own <= 1'b1;
                        rr      <= owner_id;
                    end
                OWN:
                    if (!own_req || ten_to) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        bus_own <= 1'b0;
                        bgack_n <= 1'b1;
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_bus_master_arb.sv
// tb_bus_master_arb: scoreboard bench for bus_master_arb (watchdog scenarios when BUS_ARB_WATCHDOG_EN is defined)
module tb_bus_master_arb;
    typedef struct packed {
        logic [2:0] g;
        logic [2:0] id;
    } exp_t;

    logic       cpuclk = 0;
    logic       rst_n = 0, arb_en = 1, bg_n = 1, as_n = 1, err_clr = 0;
    logic [2:0] req = 0;
    logic [2:0] gnt, owner_id;
    logic       bus_own, br_n, bgack_n, bg_err, tenure_exp;
    int         vectors = 0, miscompares = 0;
    exp_t       sb[$];
    bit         cpu_auto = 0;
    int         br_low = 0;
    logic [2:0] prev_gnt = 0;

    bus_master_arb #(.NREQ(3), .OWNER_W(3), .BG_TIMEOUT(8), .MAX_TENURE(16)) dut (
        .cpuclk(cpuclk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .gnt(gnt),
        .bus_own(bus_own), .owner_id(owner_id), .br_n(br_n), .bg_n(bg_n), .as_n(as_n),
        .bgack_n(bgack_n), .err_clr(err_clr), .bg_err(bg_err), .tenure_exp(tenure_exp)
    );

    always #5 cpuclk = ~cpuclk;

    // CPU stand-in: grants the bus once br_n has been seen low for two cycles.
    always @(posedge cpuclk) begin
        #1;
        if (cpu_auto) begin
            br_low = br_n ? 0 : br_low + 1;
            bg_n = (br_low >= 2) ? 1'b0 : 1'b1;
        end else
            br_low = 0;
    end

    // Scoreboard: every new grant must match the oldest expected grant.
    always @(posedge cpuclk) begin
        exp_t e;
        #2;
        if (gnt !== 3'b000 && prev_gnt === 3'b000) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got gnt=%b id=%0d want no grant", gnt, owner_id);
            end else begin
                e = sb.pop_front();
                if (gnt !== e.g || owner_id !== e.id) begin
                    miscompares++;
                    $display("FAIL sb_grant: got gnt=%b id=%0d want gnt=%b id=%0d", gnt, owner_id, e.g, e.id);
                end
            end
        end
        prev_gnt = gnt;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge cpuclk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 0; req = 0; arb_en = 1; bg_n = 1; as_n = 1; err_clr = 0; cpu_auto = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic wait_gnt(input string name);
        for (int i = 0; i < 40 && gnt === 3'b000; i++) tick(1);
        vectors++;
        if (gnt === 3'b000) begin
            miscompares++;
            $display("FAIL %s: got no grant within 40 cycles want grant", name);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick(2);
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        vectors++; if (bus_own !== 1'b0) begin miscompares++; $display("FAIL reset_bus_own: got %b want 0", bus_own); end
        vectors++; if (owner_id !== 3'd0) begin miscompares++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
        vectors++; if (br_n !== 1'b1 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL reset_br_bgack: got %b%b want 11", br_n, bgack_n); end
        vectors++; if (bg_err !== 1'b0 || tenure_exp !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b%b want 00", bg_err, tenure_exp); end
        rst_n = 1;
        tick(1);
    endtask

    task automatic test_basic;
        do_reset;
        req = 3'b001; sb.push_back('{3'b001, 3'd0});
        tick(1);
        vectors++; if (br_n !== 1'b0) begin miscompares++; $display("FAIL basic_br: got %b want 0", br_n); end
        tick(2);
        bg_n = 0;
        tick(3);
        vectors++; if (gnt !== 3'b000 || br_n !== 1'b0) begin miscompares++; $display("FAIL basic_wait: got gnt=%b br_n=%b want 000/0", gnt, br_n); end
        tick(1);
        vectors++; if (gnt !== 3'b001 || bgack_n !== 1'b0 || br_n !== 1'b1 || bus_own !== 1'b1) begin miscompares++; $display("FAIL basic_own: got gnt=%b bgack_n=%b br_n=%b own=%b want 001/0/1/1", gnt, bgack_n, br_n, bus_own); end
        req = 0; bg_n = 1;
        tick(1);
        vectors++; if (gnt !== 3'b000 || bgack_n !== 1'b1 || bus_own !== 1'b0) begin miscompares++; $display("FAIL basic_release: got gnt=%b bgack_n=%b own=%b want 000/1/0", gnt, bgack_n, bus_own); end
        req = 3'b001;
        tick(1);
        vectors++; if (br_n !== 1'b1) begin miscompares++; $display("FAIL basic_guard: got br_n=%b want 1", br_n); end
        tick(1);
        vectors++; if (br_n !== 1'b0) begin miscompares++; $display("FAIL basic_idle_req: got br_n=%b want 0", br_n); end
        req = 0; bg_n = 0; sb.push_back('{3'b001, 3'd0});
        tick(4);
        vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL withdraw_gnt: got %b want 001", gnt); end
        tick(1);
        vectors++; if (gnt !== 3'b000 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL withdraw_release: got gnt=%b bgack_n=%b want 000/1", gnt, bgack_n); end
        bg_n = 1;
        tick(3);
    endtask

    task automatic test_round_robin;
        exp_t e;
        do_reset;
        cpu_auto = 1;
        for (int k = 0; k < 4; k++) begin
            e.g = 3'b001 << (k % 3);
            e.id = 3'(k % 3);
            sb.push_back(e);
        end
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr_gnt");
            vectors++; if (owner_id !== 3'(k % 3) || bgack_n !== 1'b0) begin miscompares++; $display("FAIL rr_owner: got id=%0d bgack_n=%b want id=%0d bgack_n=0", owner_id, bgack_n, k % 3); end
            tick(5);
            req = req & ~gnt;
            tick(1);
            vectors++; if (gnt !== 3'b000 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL rr_release: got gnt=%b bgack_n=%b want 000/1", gnt, bgack_n); end
            req = 3'b111;
        end
        req = 0; cpu_auto = 0;
        tick(3);
    endtask

    task automatic test_wait_as;
        do_reset;
        as_n = 0; req = 3'b010; sb.push_back('{3'b010, 3'd1});
        tick(1);
        bg_n = 0;
        tick(10);
        vectors++; if (gnt !== 3'b000 || br_n !== 1'b0 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL wait_as_hold: got gnt=%b br_n=%b bgack_n=%b want 000/0/1", gnt, br_n, bgack_n); end
        as_n = 1;
        tick(2);
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL wait_as_sync: got gnt=%b want 000", gnt); end
        tick(1);
        vectors++; if (gnt !== 3'b010 || owner_id !== 3'd1) begin miscompares++; $display("FAIL wait_as_gnt: got gnt=%b id=%0d want 010/1", gnt, owner_id); end
        req = 0;
        tick(1);
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL wait_as_release: got gnt=%b want 000", gnt); end
        bg_n = 1;
        tick(3);
    endtask

    task automatic test_arb_en;
        do_reset;
        req = 3'b001;
        tick(1);
        vectors++; if (br_n !== 1'b0) begin miscompares++; $display("FAIL arb_req: got br_n=%b want 0", br_n); end
        arb_en = 0;
        tick(1);
        vectors++; if (br_n !== 1'b1 || gnt !== 3'b000) begin miscompares++; $display("FAIL arb_off_req: got br_n=%b gnt=%b want 1/000", br_n, gnt); end
        tick(3);
        vectors++; if (br_n !== 1'b1) begin miscompares++; $display("FAIL arb_off_idle: got br_n=%b want 1", br_n); end
        arb_en = 1; bg_n = 0; sb.push_back('{3'b001, 3'd0});
        wait_gnt("arb_gnt");
        arb_en = 0;
        tick(3);
        vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL arb_off_own: got gnt=%b want 001", gnt); end
        req = 0;
        tick(1);
        vectors++; if (gnt !== 3'b000 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL arb_own_release: got gnt=%b bgack_n=%b want 000/1", gnt, bgack_n); end
        bg_n = 1; arb_en = 1;
        tick(3);
    endtask

    task automatic test_reset_mid;
        do_reset;
        cpu_auto = 1; req = 3'b100; sb.push_back('{3'b100, 3'd2});
        wait_gnt("mid_gnt");
        tick(2);
        #2 rst_n = 0;
        #1;
        vectors++; if (gnt !== 3'b000 || bus_own !== 1'b0 || owner_id !== 3'd0) begin miscompares++; $display("FAIL mid_reset_gnt: got gnt=%b own=%b id=%0d want 000/0/0", gnt, bus_own, owner_id); end
        vectors++; if (bgack_n !== 1'b1 || br_n !== 1'b1) begin miscompares++; $display("FAIL mid_reset_bus: got bgack_n=%b br_n=%b want 1/1", bgack_n, br_n); end
        cpu_auto = 0; req = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

`ifdef BUS_ARB_WATCHDOG_EN
    task automatic test_bg_timeout;
        do_reset;
        req = 3'b001;
        tick(8);
        vectors++; if (br_n !== 1'b0 || bg_err !== 1'b0) begin miscompares++; $display("FAIL bgto_pending: got br_n=%b bg_err=%b want 0/0", br_n, bg_err); end
        tick(1);
        vectors++; if (br_n !== 1'b1 || bg_err !== 1'b1) begin miscompares++; $display("FAIL bgto_fire: got br_n=%b bg_err=%b want 1/1", br_n, bg_err); end
        req = 0;
        tick(3);
        vectors++; if (bg_err !== 1'b1 || gnt !== 3'b000) begin miscompares++; $display("FAIL bgto_sticky: got bg_err=%b gnt=%b want 1/000", bg_err, gnt); end
        err_clr = 1;
        tick(1);
        err_clr = 0;
        vectors++; if (bg_err !== 1'b0) begin miscompares++; $display("FAIL bgto_clear: got bg_err=%b want 0", bg_err); end
        tick(2);
    endtask

    task automatic test_tenure;
        do_reset;
        cpu_auto = 1; req = 3'b011;
        sb.push_back('{3'b001, 3'd0});
        sb.push_back('{3'b010, 3'd1});
        wait_gnt("ten_gnt");
        tick(15);
        vectors++; if (gnt !== 3'b001 || tenure_exp !== 1'b0) begin miscompares++; $display("FAIL ten_hold: got gnt=%b exp=%b want 001/0", gnt, tenure_exp); end
        tick(1);
        vectors++; if (gnt !== 3'b000 || tenure_exp !== 1'b1 || bgack_n !== 1'b1) begin miscompares++; $display("FAIL ten_expire: got gnt=%b exp=%b bgack_n=%b want 000/1/1", gnt, tenure_exp, bgack_n); end
        req = 3'b010;
        tick(1);
        vectors++; if (tenure_exp !== 1'b0) begin miscompares++; $display("FAIL ten_pulse: got exp=%b want 0", tenure_exp); end
        wait_gnt("ten_next");
        vectors++; if (owner_id !== 3'd1) begin miscompares++; $display("FAIL ten_next_owner: got id=%0d want 1", owner_id); end
        req = 0; cpu_auto = 0;
        tick(3);
    endtask
`else
    task automatic test_no_watchdog;
        do_reset;
        req = 3'b001;
        tick(300);
        vectors++; if (br_n !== 1'b0 || bg_err !== 1'b0) begin miscompares++; $display("FAIL nowd_req: got br_n=%b bg_err=%b want 0/0", br_n, bg_err); end
        arb_en = 0;
        tick(1);
        arb_en = 1; cpu_auto = 1; sb.push_back('{3'b001, 3'd0});
        wait_gnt("nowd_gnt");
        tick(40);
        vectors++; if (gnt !== 3'b001 || tenure_exp !== 1'b0) begin miscompares++; $display("FAIL nowd_own: got gnt=%b exp=%b want 001/0", gnt, tenure_exp); end
        req = 0; cpu_auto = 0;
        tick(3);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_round_robin;
        test_wait_as;
        test_arb_en;
        test_reset_mid;
`ifdef BUS_ARB_WATCHDOG_EN
        test_bg_timeout;
        test_tenure;
`else
        test_no_watchdog;
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d grants outstanding want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
